// File: rtl/coffee_vend_ctrl.sv
// Coin-operated two-drink vending controller with change return and cancel/refund.
// Optional idle auto-refund in COLLECT is built only when AUTO_REFUND_EN is defined.
module coffee_vend_ctrl #(
    parameter int CREDIT_W    = 8,
    parameter int COIN1_VAL   = 1,
    parameter int COIN2_VAL   = 2,
    parameter int COIN3_VAL   = 5,
    parameter int PRICE_A     = 3,
    parameter int PRICE_B     = 4,
    parameter int CHANGE_UNIT = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin1,
    input  logic                coin2,
    input  logic                coin3,
    input  logic                sel,
    input  logic                cancel,
    output logic                cafea,
    output logic                cafea_sel,
    output logic                rest,
    output logic                reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    // Headroom so a full accumulator plus all three coins cannot wrap before the limit check.
    localparam int SUM_W = CREDIT_W + 4;
    localparam logic [SUM_W-1:0] CREDIT_MAX = {{(SUM_W - CREDIT_W){1'b0}}, {CREDIT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          coin_q;
    logic [2:0]          coin_edge;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic                sel_q, sel_d;
    logic                cafea_q, cafea_d;
    logic                rest_q, rest_d;
    logic                reject_q, reject_d;
    logic                busy_q, busy_d;
    logic [SUM_W-1:0]    deposit, total, credit_ext, new_credit, price_sel;
    logic                any_edge, accept, refund_req, tmo_hit;

    assign coin_edge  = {coin3, coin2, coin1} & ~coin_q;
    assign any_edge   = |coin_edge;
    assign deposit    = (coin_edge[0] ? SUM_W'(COIN1_VAL) : '0)
                      + (coin_edge[1] ? SUM_W'(COIN2_VAL) : '0)
                      + (coin_edge[2] ? SUM_W'(COIN3_VAL) : '0);
    assign credit_ext = SUM_W'(credit_q);
    assign total      = credit_ext + deposit;
    assign accept     = any_edge && (total <= CREDIT_MAX);
    assign new_credit = accept ? total : credit_ext;
    assign price_sel  = sel ? SUM_W'(PRICE_B) : SUM_W'(PRICE_A);
    assign refund_req = cancel || tmo_hit;

`ifdef AUTO_REFUND_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (state_q == COLLECT) && !accept && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == COLLECT && state_d == COLLECT && !accept)
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        credit_d = credit_q;
        price_d  = price_q;
        sel_d    = sel_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                reject_d = any_edge && !accept;
                if (accept) begin
                    credit_d = total[CREDIT_W-1:0];
                    if (total >= price_sel) begin
                        state_d = VEND;
                        price_d = price_sel[CREDIT_W-1:0];
                        sel_d   = sel;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (refund_req) begin
                    state_d  = CHANGE;
                    reject_d = any_edge;
                end else begin
                    reject_d = any_edge && !accept;
                    credit_d = new_credit[CREDIT_W-1:0];
                    // Re-evaluated every cycle, so a later sel change can also complete a purchase.
                    if (new_credit >= price_sel) begin
                        state_d = VEND;
                        price_d = price_sel[CREDIT_W-1:0];
                        sel_d   = sel;
                    end
                end
            end
            VEND: begin
                reject_d = any_edge;
                credit_d = credit_q - price_q;
                state_d  = (credit_q > price_q) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = any_edge;
                if (credit_q <= CREDIT_W'(CHANGE_UNIT)) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - CREDIT_W'(CHANGE_UNIT);
                end
            end
            default: state_d = IDLE;
        endcase
        cafea_d = (state_d == VEND);
        rest_d  = (state_d == CHANGE);
        busy_d  = cafea_d || rest_d;
    end

    // NOTE: state and output flops use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            coin_q   <= '1;
            credit_q <= '0;
            price_q  <= '0;
            sel_q    <= 1'b0;
            cafea_q  <= 1'b0;
            rest_q   <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            coin_q   <= {coin3, coin2, coin1};
            credit_q <= credit_d;
            price_q  <= price_d;
            sel_q    <= sel_d;
            cafea_q  <= cafea_d;
            rest_q   <= rest_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    assign cafea     = cafea_q;
    assign cafea_sel = sel_q;
    assign rest      = rest_q;
    assign reject    = reject_q;
    assign busy      = busy_q;
    assign credit    = credit_q;

endmodule

// File: tb/tb_coffee_vend_ctrl.sv
// Directed bench for coffee_vend_ctrl: a transaction-level credit/plan model checked every cycle,
// plus literal expectations; the auto-refund case follows AUTO_REFUND_EN.
module tb_coffee_vend_ctrl;

    localparam int TIMEOUT = 16;
    localparam int MAXCR   = 255;

    logic       clk;
    logic       rst_n;
    logic       coin1, coin2, coin3, sel, cancel;
    logic       cafea, cafea_sel, rest, reject, busy;
    logic [7:0] credit;

    int vectors     = 0;
    int miscompares = 0;
    int rest_cnt    = 0;
    int reject_cnt  = 0;
    int cafea_cnt   = 0;
    int busy_cnt    = 0;

    coffee_vend_ctrl dut (
        .clk       (clk),
        .reset     (rst_n),
        .coin1     (coin1),
        .coin2     (coin2),
        .coin3     (coin3),
        .sel       (sel),
        .cancel    (cancel),
        .cafea     (cafea),
        .cafea_sel (cafea_sel),
        .rest      (rest),
        .reject    (reject),
        .busy      (busy),
        .credit    (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Model: credit held while idle/collecting; a purchase or refund expands into a queue of
    // per-cycle output frames that play out before coins are accepted again.
    typedef struct {
        bit cafea;
        bit csel;
        bit rest;
        bit busy;
        int credit;
    } frame_t;

    frame_t     plan[$];
    frame_t     exp_f;
    bit         exp_rej;
    bit         m_valid;
    bit   [2:0] m_prev;
    int         m_credit;
    int         m_quiet;

    task automatic push_frame(input bit ca, input bit cs, input bit rs, input bit bz, input int cr);
        frame_t f;
        f.cafea = ca; f.csel = cs; f.rest = rs; f.busy = bz; f.credit = cr;
        plan.push_back(f);
    endtask

    task automatic model_reset();
        plan.delete();
        m_prev   = 3'b111;
        m_credit = 0;
        m_quiet  = 0;
        m_valid  = 1'b0;
        exp_rej  = 1'b0;
    endtask

    task automatic model_step();
        bit [2:0] cin, e;
        bit       any, collecting, refund, accept;
        int       dep, price;
        cin    = {coin3, coin2, coin1};
        e      = cin & ~m_prev;
        m_prev = cin;
        any    = |e;
        dep    = (e[0] ? 1 : 0) + (e[1] ? 2 : 0) + (e[2] ? 5 : 0);
        if (plan.size() != 0) begin
            exp_f   = plan.pop_front();
            exp_rej = any;
        end else begin
            collecting = (m_credit > 0);
            refund     = collecting && cancel;
            accept     = any && !refund && (m_credit + dep <= MAXCR);
            exp_rej    = any && !accept;
            if (accept) m_credit += dep;
`ifdef AUTO_REFUND_EN
            if (collecting && !refund && !accept) m_quiet++;
            else m_quiet = 0;
            if (m_quiet >= TIMEOUT) refund = 1'b1;
`endif
            price = sel ? 4 : 3;
            if (refund) begin
                for (int k = 0; k < m_credit; k++) push_frame(0, 0, 1, 1, m_credit - k);
                push_frame(0, 0, 0, 0, 0);
                m_credit = 0;
                m_quiet  = 0;
            end else if (m_credit > 0 && m_credit >= price) begin
                push_frame(1, sel, 0, 1, m_credit);
                for (int k = 0; k < m_credit - price; k++) push_frame(0, 0, 1, 1, m_credit - price - k);
                push_frame(0, 0, 0, 0, 0);
                m_credit = 0;
                m_quiet  = 0;
            end
            if (plan.size() != 0) begin
                exp_f = plan.pop_front();
            end else begin
                exp_f.cafea = 0; exp_f.csel = 0; exp_f.rest = 0; exp_f.busy = 0;
                exp_f.credit = m_credit;
            end
        end
        m_valid = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare and event counters, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                rest_cnt   += int'(rest);
                reject_cnt += int'(reject);
                cafea_cnt  += int'(cafea);
                busy_cnt   += int'(busy);
                if (m_valid) begin
                    check("credit", credit, 16'(exp_f.credit));
                    check("cafea",  cafea,  exp_f.cafea);
                    check("rest",   rest,   exp_f.rest);
                    check("busy",   busy,   exp_f.busy);
                    check("reject", reject, exp_rej);
                    if (exp_f.cafea) check("cafea_sel", cafea_sel, exp_f.csel);
                end
            end
        end
    end

    task automatic coin_pulse(input logic [2:0] mask);
        @(negedge clk);
        {coin3, coin2, coin1} = mask;
        @(negedge clk);
        {coin3, coin2, coin1} = 3'b000;
    endtask

    task automatic cancel_pulse();
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_credit"}, credit, 0);
        check({tag, "_outs"}, {cafea, cafea_sel, rest, reject, busy}, 0);
    endtask

    int  r0, j0, c0, b0;
    bit  seen;

    task automatic snap();
        r0 = rest_cnt; j0 = reject_cnt; c0 = cafea_cnt; b0 = busy_cnt;
    endtask

    initial begin
        rst_n = 1'b0;
        {coin3, coin2} = 2'b00;
        coin1  = 1'b1;
        sel    = 1'b0;
        cancel = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        #2 rst_n = 1'b1;

        // Coin1 held high through reset release must not count.
        repeat (3) @(negedge clk);
        check("held_coin1_credit", credit, 0);
        coin1 = 1'b0;
        @(negedge clk);

        // T1: 1 + 1 + 2 with drink A.
        snap();
        coin_pulse(3'b001); check("t1_credit1", credit, 1);
        coin_pulse(3'b001); check("t1_credit2", credit, 2);
        coin_pulse(3'b010); check("t1_credit4", credit, 4);
        check("t1_cafea", cafea, 1);
        check("t1_sel", cafea_sel, 0);
        repeat (4) @(negedge clk);
        check("t1_rests", 16'(rest_cnt - r0), 1);
        check("t1_cafeas", 16'(cafea_cnt - c0), 1);
        check("t1_credit_end", credit, 0);

        // T2: coin3 with drink B; sel flipped after the latch must not matter.
        sel = 1'b1;
        snap();
        coin_pulse(3'b100);
        sel = 1'b0;
        check("t2_credit5", credit, 5);
        check("t2_sel", cafea_sel, 1);
        repeat (4) @(negedge clk);
        check("t2_rests", 16'(rest_cnt - r0), 1);
        check("t2_busy", 16'(busy_cnt - b0), 2);

        // T3: coin2 then cancel gives a two-unit refund.
        snap();
        coin_pulse(3'b010); check("t3_credit2", credit, 2);
        cancel_pulse();
        check("t3_rest_now", rest, 1);
        repeat (4) @(negedge clk);
        check("t3_rests", 16'(rest_cnt - r0), 2);
        check("t3_cafeas", 16'(cafea_cnt - c0), 0);
        check("t3_credit_end", credit, 0);

        // T4: coin3 with drink A, coin1 during change is refused.
        snap();
        coin_pulse(3'b100);
        @(negedge clk); coin1 = 1'b1;
        @(negedge clk); coin1 = 1'b0;
        check("t4_reject_now", reject, 1);
        repeat (4) @(negedge clk);
        check("t4_rests", 16'(rest_cnt - r0), 2);
        check("t4_rejects", 16'(reject_cnt - j0), 1);

        // All three coins in one cycle: 8 credit, drink A, five rest pulses.
        snap();
        coin_pulse(3'b111);
        check("sim_credit8", credit, 8);
        repeat (8) @(negedge clk);
        check("sim_rests", 16'(rest_cnt - r0), 5);
        check("sim_credit_end", credit, 0);

        // Cancel in IDLE is ignored; sel change later completes a purchase with no change.
        sel = 1'b1;
        snap();
        @(negedge clk); cancel = 1'b1; coin1 = 1'b1;
        @(negedge clk); cancel = 1'b0; coin1 = 1'b0;
        check("idle_cancel_credit", credit, 1);
        coin_pulse(3'b010); check("selchg_credit3", credit, 3);
        check("selchg_no_cafea", cafea, 0);
        sel = 1'b0;
        @(negedge clk);
        check("selchg_cafea", cafea, 1);
        check("selchg_sel", cafea_sel, 0);
        repeat (3) @(negedge clk);
        check("selchg_rests", 16'(rest_cnt - r0), 0);

        // Cancel and a coin edge together in COLLECT: coin refused, refund of the prior credit.
        snap();
        coin_pulse(3'b001);
        @(negedge clk); cancel = 1'b1; coin2 = 1'b1;
        @(negedge clk); cancel = 1'b0; coin2 = 1'b0;
        check("cxl_coin_reject", reject, 1);
        repeat (3) @(negedge clk);
        check("cxl_rests", 16'(rest_cnt - r0), 1);
        check("cxl_credit_end", credit, 0);

        // T5: asynchronous reset in the middle of a refund.
        coin_pulse(3'b010);
        cancel_pulse();
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        coin1 = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_held_credit", credit, 0);
        coin1 = 1'b0;
        @(negedge clk);

        // T6: idle behaviour after a single coin.
        snap();
        coin_pulse(3'b001);
        check("t6_credit1", credit, 1);
`ifdef AUTO_REFUND_EN
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rest) seen = 1'b1;
        end
        check("t6_auto_refund_seen", seen, 1);
        repeat (3) @(negedge clk);
        check("t6_rests", 16'(rest_cnt - r0), 1);
        check("t6_credit_end", credit, 0);
`else
        repeat (100) @(negedge clk);
        check("t6_credit_hold", credit, 1);
        check("t6_no_rest", 16'(rest_cnt - r0), 0);
        cancel_pulse();
        repeat (3) @(negedge clk);
        check("t6_credit_end", credit, 0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
